psx_state_loader: RTL and testbench

- Upstream feeder for the DualShock emulator. Its write_addr/write_data/write_en outputs drive the emulator's 32-byte input-state write port directly.
- Receives framed controller-state updates as a byte stream from the host link (USB/serial FIFO, valid/ready).
- Validates each frame and buffers its data.
- Commits a frame to the emulator only when the checksum passes, so a polling console never sees a partially applied update.

---
 rtl/psx_pkg.sv | 38 +++
 rtl/psx_frame_buffer.sv | 38 +++
 rtl/psx_state_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_psx_state_loader.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_pkg.sv
// Purpose: shared constants, state encoding and header type for the DualShock state loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psx_pkg;

    // Frame start marker on the host link.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Emulator input-state size and address width.
    localparam int MAX_COUNT  = 32;
    localparam int PSX_ADDR_W = 5;

    // COUNT may be 32, so the byte counter needs one bit more than the address.
    localparam int CNT_W = 6;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_SYNC   = 3'd0,
        S_ADDR   = 3'd1,
        S_COUNT  = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_COMMIT = 3'd5
    } state_e;

    // Latched frame header: start address and byte count.
    typedef struct packed {
        logic [PSX_ADDR_W-1:0] start;
        logic [CNT_W-1:0]      count;
    } hdr_t;

    // COUNT is legal when it selects between 1 and MAX_COUNT bytes.
    function automatic logic count_valid(input logic [7:0] c);
        return (c != 8'd0) && (c <= 8'(MAX_COUNT));
    endfunction

endpackage

// File: rtl/psx_frame_buffer.sv
// Purpose: 32x8 holding buffer for the data bytes of one frame, one write and one read port.
// Latency: write lands at the clock edge; read data is registered, valid one cycle after rd_en_i.
// Backpressure: none, both ports accept every cycle.
module psx_frame_buffer
    import psx_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [PSX_ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]            wr_dat_i,
    input  logic                  rd_en_i,
    input  logic [PSX_ADDR_W-1:0] rd_addr_i,
    output logic [7:0]            rd_dat_o
);

    logic [7:0] mem_q [MAX_COUNT];
    logic [7:0] rd_dat_q;

    // Storage array; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    // Registered read so the data lines up with the registered write address/strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_dat_q <= 8'd0;
        end else if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/psx_state_loader.sv
// Purpose: parse framed host bytes (A5, ADDR, COUNT, DATA, CSUM) and commit checked frames to the emulator input state.
// Latency: first write the cycle after CSUM is accepted, COUNT back-to-back writes, frame_ok the cycle after the last write.
// Backpressure: in_ready low only while committing; optional error counter enabled by PSX_LOADER_ERRCNT_EN.
module psx_state_loader
    import psx_pkg::*;
#(
    parameter int CLOCK_MHZ  = 25,
    parameter int TIMEOUT_US = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PSX_ADDR_W-1:0] write_addr,
    output logic [7:0]            write_data,
    output logic                  write_en,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic                  busy
`ifdef PSX_LOADER_ERRCNT_EN
    ,
    output logic [15:0]           err_count
`endif
);

    // Inter-byte timeout, in clock cycles minus one.
    localparam int TO_RELOAD = CLOCK_MHZ * TIMEOUT_US - 1;
    localparam int TO_W      = (TO_RELOAD > 0) ? $clog2(TO_RELOAD + 1) : 1;

    state_e                state_q, state_d;
    hdr_t                  hdr_q, hdr_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic                  wr_en_q, wr_en_d;
    logic [PSX_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;

    logic                  acc;
    logic                  waiting;
    logic                  expired;
    logic [CNT_W-1:0]      idx_nxt;
    logic                  buf_we;
    logic                  buf_re;
    logic [PSX_ADDR_W-1:0] buf_raddr;
    logic [7:0]            buf_rdat;

    assign in_ready = (state_q != S_COMMIT);
    assign acc      = in_valid && in_ready;
    assign waiting  = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    // An accepted byte on the expiry cycle takes priority over the timeout.
    assign expired  = waiting && !acc && (to_q == '0);
    assign idx_nxt  = idx_q + 1'b1;

    psx_frame_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (buf_we),
        .wr_addr_i (idx_q[PSX_ADDR_W-1:0]),
        .wr_dat_i  (in_data),
        .rd_en_i   (buf_re),
        .rd_addr_i (buf_raddr),
        .rd_dat_o  (buf_rdat)
    );

    // Next-state, parse/commit control and registered-output next values.
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        to_d      = to_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        buf_we    = 1'b0;
        buf_re    = 1'b0;
        buf_raddr = '0;

        // Reload on any accepted byte, count down while a frame is open.
        if (acc) begin
            to_d = TO_W'(TO_RELOAD);
        end else if (waiting && (to_q != '0)) begin
            to_d = to_q - 1'b1;
        end

        case (state_q)
            S_SYNC: begin
                // Anything other than the sync marker is dropped without complaint.
                if (acc && (in_data == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                if (acc) begin
                    if (in_data[7:PSX_ADDR_W] == '0) begin
                        hdr_d.start = in_data[PSX_ADDR_W-1:0];
                        csum_d      = in_data;
                        state_d     = S_COUNT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_SYNC;
                    end
                end
            end

            S_COUNT: begin
                if (acc) begin
                    if (count_valid(in_data)) begin
                        hdr_d.count = in_data[CNT_W-1:0];
                        csum_d      = csum_q + in_data;
                        idx_d       = '0;
                        state_d     = S_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_SYNC;
                    end
                end
            end

            S_DATA: begin
                if (acc) begin
                    buf_we = 1'b1;
                    csum_d = csum_q + in_data;
                    idx_d  = idx_nxt;
                    if (idx_nxt == hdr_q.count) begin
                        state_d = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                if (acc) begin
                    if (in_data == csum_q) begin
                        // Issue write 0 right away so it appears the next cycle.
                        wr_en_d   = 1'b1;
                        wr_addr_d = hdr_q.start;
                        buf_re    = 1'b1;
                        buf_raddr = '0;
                        idx_d     = CNT_W'(1);
                        state_d   = S_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_SYNC;
                    end
                end
            end

            S_COMMIT: begin
                // idx_q counts writes already issued; the address wraps naturally at 5 bits.
                if (idx_q < hdr_q.count) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = hdr_q.start + idx_q[PSX_ADDR_W-1:0];
                    buf_re    = 1'b1;
                    buf_raddr = idx_q[PSX_ADDR_W-1:0];
                    idx_d     = idx_nxt;
                end else begin
                    ok_d    = 1'b1;
                    state_d = S_SYNC;
                end
            end

            default: begin
                state_d = S_SYNC;
            end
        endcase

        if (expired) begin
            err_d   = 1'b1;
            state_d = S_SYNC;
        end
    end

    // State and registered outputs; reset abandons any commit in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_SYNC;
            hdr_q     <= '0;
            idx_q     <= '0;
            csum_q    <= 8'd0;
            to_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            to_q      <= to_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
        end
    end

    assign write_en   = wr_en_q;
    assign write_addr = wr_addr_q;
    assign write_data = buf_rdat;
    assign frame_ok   = ok_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != S_SYNC);

`ifdef PSX_LOADER_ERRCNT_EN
    logic [15:0] errcnt_q;

    // Saturating count of rejected frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            errcnt_q <= 16'd0;
        end else if (err_q && (errcnt_q != 16'hFFFF)) begin
            errcnt_q <= errcnt_q + 16'd1;
        end
    end

    assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_psx_state_loader.sv
// Purpose: self-checking bench for psx_state_loader (vector table, corner sequences, random frames vs event model).
// Latency: n/a.
// Backpressure: bench holds in_valid until in_ready, bounded.
module tb_psx_state_loader;

    localparam int TO_CYC = 10;  // CLOCK_MHZ(1) * TIMEOUT_US(10)

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] write_addr;
    logic [7:0] write_data;
    logic       write_en;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;
`ifdef PSX_LOADER_ERRCNT_EN
    logic [15:0] err_count;
`endif

    always #5 clk = ~clk;

    psx_state_loader #(.CLOCK_MHZ(1), .TIMEOUT_US(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef PSX_LOADER_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- event model ----------------
    // kind: 0 write, 1 frame_ok, 2 frame_err. t = edge count after which the output is visible.
    typedef struct {
        int         t;
        int         kind;
        logic [4:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    bit         model_en   = 1'b0;
    bit         m_in_frame = 1'b0;
    int         m_last     = 0;
    int         m_commit_end = -1;
    logic [7:0] m_fr[$];

    function automatic void push_exp(input int t, input int k, input logic [4:0] a, input logic [7:0] d);
        ev_t ev;
        ev.t = t; ev.kind = k; ev.a = a; ev.d = d;
        exp_q.push_back(ev);
    endfunction

    // Frame rules applied to the accepted-byte stream; e = edge at which the byte was taken.
    task automatic model_accept(input logic [7:0] b, input int e);
        int n, cnt, sum;
        check("no_accept_during_commit", 64'(e > m_commit_end), 64'd1);
        if (m_in_frame && (e > m_last + TO_CYC)) begin
            push_exp(m_last + TO_CYC, 2, 5'd0, 8'd0);
            m_in_frame = 1'b0;
        end
        m_last = e;
        if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame = 1'b1;
                m_fr.delete();
            end
            return;
        end
        m_fr.push_back(b);
        n = m_fr.size();
        if (n == 1) begin
            if (b[7:5] != 3'd0) begin push_exp(e, 2, 5'd0, 8'd0); m_in_frame = 1'b0; end
        end else if (n == 2) begin
            if (b == 8'd0 || b > 8'd32) begin push_exp(e, 2, 5'd0, 8'd0); m_in_frame = 1'b0; end
        end else begin
            cnt = int'(m_fr[1]);
            if (n == cnt + 3) begin
                sum = 0;
                for (int i = 0; i < n - 1; i++) sum += int'(m_fr[i]);
                if ((sum % 256) == int'(b)) begin
                    for (int i = 0; i < cnt; i++)
                        push_exp(e + i, 0, 5'((int'(m_fr[0]) + i) % 32), m_fr[2 + i]);
                    push_exp(e + cnt, 1, 5'd0, 8'd0);
                    m_commit_end = e + cnt;
                end else begin
                    push_exp(e, 2, 5'd0, 8'd0);
                end
                m_in_frame = 1'b0;
            end
        end
    endtask

    task automatic model_flush();
        if (m_in_frame && (cyc > m_last + TO_CYC)) begin
            push_exp(m_last + TO_CYC, 2, 5'd0, 8'd0);
            m_in_frame = 1'b0;
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (model_en && !reset) begin
            ev_t ev;
            if (write_en)  begin ev.t = cyc; ev.kind = 0; ev.a = write_addr; ev.d = write_data; obs_q.push_back(ev); end
            if (frame_ok)  begin ev.t = cyc; ev.kind = 1; ev.a = 5'd0; ev.d = 8'd0; obs_q.push_back(ev); end
            if (frame_err) begin ev.t = cyc; ev.kind = 2; ev.a = 5'd0; ev.d = 8'd0; obs_q.push_back(ev); end
            if (in_valid && in_ready) model_accept(in_data, cyc + 1);
        end
    end

    // ---------------- driver helpers ----------------
    // Called just after a rising edge; returns just after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        w = 0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 200) begin
                check("send_byte_wait_bound", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int         s_err, s_ok, s_nw;
    logic [4:0] s_a [64];
    logic [7:0] s_d [64];

    task automatic scan(input int i0);
        s_err = 0; s_ok = 0; s_nw = 0;
        for (int i = i0; i < obs_q.size(); i++) begin
            case (obs_q[i].kind)
                0: begin
                    if (s_nw < 64) begin s_a[s_nw] = obs_q[i].a; s_d[s_nw] = obs_q[i].d; end
                    s_nw++;
                end
                1: s_ok++;
                default: s_err++;
            endcase
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          n;
        logic [95:0] bytes;   // right-aligned, first byte most significant
        int          exp_err;
        int          exp_ok;
        int          exp_nw;
        logic [4:0]  a0;
        logic [31:0] ed;      // expected write data, first write in the top byte
    } vec_t;

    vec_t vecs[10];

    initial begin
        int         i0, stalls, sum, keep, k, cnt, g;
        bit         long_next;
        logic [7:0] fb[$];
        logic [7:0] b, addr;

        vecs[0] = '{7, 96'hA5_04_03_11_22_33_6D,    0, 1, 3, 5'd4,  32'h11223300};
        vecs[1] = '{8, 96'hA5_1E_04_01_02_03_04_2C, 0, 1, 4, 5'd30, 32'h01020304};
        vecs[2] = '{5, 96'hA5_00_01_FF_01,          1, 0, 0, 5'd0,  32'h0};
        vecs[3] = '{5, 96'hA5_00_01_FF_00,          0, 1, 1, 5'd0,  32'hFF000000};
        vecs[4] = '{3, 96'hA5_00_00,                1, 0, 0, 5'd0,  32'h0};
        vecs[5] = '{2, 96'hA5_20,                   1, 0, 0, 5'd0,  32'h0};
        vecs[6] = '{3, 96'hA5_00_21,                1, 0, 0, 5'd0,  32'h0};
        vecs[7] = '{7, 96'h00_FF_A5_1F_01_5A_7A,    0, 1, 1, 5'd31, 32'h5A000000};
        vecs[8] = '{5, 96'hA5_03_01_A5_A9,          0, 1, 1, 5'd3,  32'hA5000000};
        vecs[9] = '{6, 96'hA5_1F_02_11_22_55,       1, 0, 0, 5'd0,  32'h0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_write_en",   64'(write_en),   64'd0);
        check("rst_write_addr", 64'(write_addr), 64'd0);
        check("rst_write_data", 64'(write_data), 64'd0);
        check("rst_frame_ok",   64'(frame_ok),   64'd0);
        check("rst_frame_err",  64'(frame_err),  64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        model_en = 1'b1;

        // Table-driven frames, each sent back-to-back and allowed to settle.
        for (int v = 0; v < 10; v++) begin
            i0 = obs_q.size();
            for (int i = 0; i < vecs[v].n; i++)
                send_byte(vecs[v].bytes[8*(vecs[v].n-1-i) +: 8], 0);
            wait_cycles(45);
            scan(i0);
            check($sformatf("v%0d_err", v), 64'(s_err), 64'(vecs[v].exp_err));
            check($sformatf("v%0d_ok", v),  64'(s_ok),  64'(vecs[v].exp_ok));
            check($sformatf("v%0d_nw", v),  64'(s_nw),  64'(vecs[v].exp_nw));
            for (int j = 0; j < vecs[v].exp_nw && j < s_nw; j++) begin
                logic [4:0] ea;
                ea = vecs[v].a0 + 5'(j);
                check($sformatf("v%0d_w%0d_addr", v, j), 64'(s_a[j]), 64'(ea));
                check($sformatf("v%0d_w%0d_data", v, j), 64'(s_d[j]), 64'(vecs[v].ed[31-8*j -: 8]));
            end
        end

        // Timeout: A5 02 then silence; error exactly TO_CYC edges after the last byte.
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        repeat (9) @(negedge clk);
        @(negedge clk);
        check("to_no_err_before", 64'(frame_err), 64'd0);
        check("to_busy_before",   64'(busy),      64'd1);
        @(negedge clk);
        check("to_err_pulse",     64'(frame_err), 64'd1);
        check("to_busy_dropped",  64'(busy),      64'd0);
        @(negedge clk);
        check("to_err_one_cycle", 64'(frame_err), 64'd0);
        @(posedge clk);
        #1;

        // Bytes landing exactly on the expiry cycle keep the frame alive.
        i0 = obs_q.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, TO_CYC - 1);
        send_byte(8'h77, TO_CYC - 1);
        send_byte(8'h7A, TO_CYC - 1);
        wait_cycles(20);
        scan(i0);
        check("exp_win_err", 64'(s_err), 64'd0);
        check("exp_win_ok",  64'(s_ok),  64'd1);
        check("exp_win_nw",  64'(s_nw),  64'd1);
        check("exp_win_w0",  64'({s_a[0], s_d[0]}), 64'({5'd2, 8'h77}));

        // Backpressure: 32-byte frame, next A5 held during the commit.
        i0 = obs_q.size();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        sum = 8'h20;
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * 7 + 1);
            sum += int'(b);
            send_byte(b, 0);
        end
        send_byte(8'(sum % 256), 0);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        stalls   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
        end
        check("bp_stall_cycles", 64'(stalls), 64'd32);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_a5_taken_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        send_byte(8'h58, 0);
        wait_cycles(20);
        scan(i0);
        check("bp_nw",  64'(s_nw),  64'd33);
        check("bp_ok",  64'(s_ok),  64'd2);
        check("bp_err", 64'(s_err), 64'd0);

        // Random frames checked against the event model.
        long_next = 1'b0;
        for (int f = 0; f < 60; f++) begin
            fb.delete();
            k = $urandom_range(0, 9);
            if (k == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hA5) b = 8'h00;
                    fb.push_back(b);
                end
            end else if (k == 1) begin
                fb.push_back(8'hA5);
                fb.push_back({3'($urandom_range(1, 7)), 5'($urandom_range(0, 31))});
            end else if (k == 2) begin
                fb.push_back(8'hA5);
                fb.push_back(8'($urandom_range(0, 31)));
                fb.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
            end else begin
                cnt  = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 32) : $urandom_range(1, 8);
                addr = 8'($urandom_range(0, 31));
                fb.push_back(8'hA5);
                fb.push_back(addr);
                fb.push_back(8'(cnt));
                sum = int'(addr) + cnt;
                for (int i = 0; i < cnt; i++) begin
                    b = 8'($urandom_range(0, 255));
                    sum += int'(b);
                    fb.push_back(b);
                end
                b = 8'(sum % 256);
                if (k == 3) b = b ^ 8'($urandom_range(1, 255));
                fb.push_back(b);
                if (k == 4) begin
                    keep = $urandom_range(1, fb.size() - 1);
                    while (fb.size() > keep) void'(fb.pop_back());
                end
            end
            for (int i = 0; i < fb.size(); i++) begin
                g = ($urandom_range(0, 19) == 0) ? $urandom_range(8, 11) : $urandom_range(0, 2);
                if (i == 0 && long_next) g = TO_CYC + 2;
                send_byte(fb[i], g);
            end
            long_next = (k == 4);
        end
        wait_cycles(20);
        model_flush();

        check("model_event_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("ev%0d", i),
                  {obs_q[i].t[31:0], 8'(obs_q[i].kind), 3'b000, obs_q[i].a, 8'h00, obs_q[i].d},
                  {exp_q[i].t[31:0], 8'(exp_q[i].kind), 3'b000, exp_q[i].a, 8'h00, exp_q[i].d});
        end

`ifdef PSX_LOADER_ERRCNT_EN
        scan(0);
        check("err_count", 64'(err_count), 64'(s_err));
`endif

        // Reset during a commit stops the write strobe on the next edge.
        model_en = 1'b0;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        sum = 8'h20;
        for (int i = 0; i < 32; i++) begin
            sum += 3;
            send_byte(8'h03, 0);
        end
        send_byte(8'(sum % 256), 0);
        repeat (5) @(negedge clk);
        check("rstc_writing", 64'(write_en), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rstc_still_writing", 64'(write_en), 64'd1);
        @(negedge clk);
        check("rstc_write_en_off", 64'(write_en), 64'd0);
        check("rstc_busy_off",     64'(busy),     64'd0);
        check("rstc_in_ready",     64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
